// File: rtl/sync_down_counter.sv
// Loadable synchronous down-counter used as an interval timer or event divider.
// One-shot stops at 0; auto-reload wraps from 1 back to the captured load value.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n, reload_reg, reload_n;
  logic             mode_reg, mode_n, borrow_n;

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    mode_n   = mode_reg;
    borrow_n = 1'b0;
    if (clr) begin
      state_n = IDLE;
      count_n = '0;
    end else if (load) begin
      count_n  = load_val;
      reload_n = load_val;
      mode_n   = mode;
      state_n  = (load_val != '0) ? RUN : IDLE;
    end else if (state == RUN && en) begin
      // RUN never holds 0, so the terminal step is always taken from 1.
      if (count > WIDTH'(1)) begin
        count_n = count - WIDTH'(1);
      end else if (mode_reg) begin
        count_n  = reload_reg;
        borrow_n = 1'b1;
      end else begin
        count_n  = '0;
        borrow_n = 1'b1;
        state_n  = IDLE;
      end
    end
  end

  // zero/busy derive from next-state values so they change on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
      zero       <= 1'b1;
      borrow     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      mode_reg   <= mode_n;
      zero       <= (count_n == '0);
      borrow     <= borrow_n;
      busy       <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter with hand-computed expected sequences.
module tb_sync_down_counter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst, clr, load, mode, en;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             zero, borrow, busy;

  int total = 0;
  int bad   = 0;

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .mode(mode), .en(en), .count(count), .zero(zero), .borrow(borrow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input int z, input int b, input int u);
    chk({tag, ".count"},  int'(count),  c);
    chk({tag, ".zero"},   int'(zero),   z);
    chk({tag, ".borrow"}, int'(borrow), b);
    chk({tag, ".busy"},   int'(busy),   u);
  endtask

  initial begin
    int os_seq[5]  = '{4, 3, 2, 1, 0};
    int ar_seq[8]  = '{2, 1, 3, 2, 1, 3, 2, 1};
    int gap_seq[7] = '{3, 3, 2, 2, 1, 1, 0};
    int nborrow;
    int cyc;

    rst = 1'b1; clr = 1'b0; load = 1'b1; load_val = 4'd9; mode = 1'b1; en = 1'b1;
    step(); step();
    chk_all("reset", 0, 1, 0, 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    step();
    chk_all("idle_after_reset", 0, 1, 0, 0);

    // one-shot 5
    load = 1'b1; load_val = 4'd5; mode = 1'b0; en = 1'b1;
    step();
    chk_all("os_load", 5, 0, 0, 1);
    load = 1'b0;
    foreach (os_seq[i]) begin
      step();
      chk_all("os_run", os_seq[i], (os_seq[i] == 0) ? 1 : 0, (os_seq[i] == 0) ? 1 : 0,
              (os_seq[i] == 0) ? 0 : 1);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("os_hold", 0, 1, 0, 0);
    end

    // auto-reload 3
    load = 1'b1; load_val = 4'd3; mode = 1'b1;
    step();
    chk_all("ar_load", 3, 0, 0, 1);
    load = 1'b0;
    foreach (ar_seq[i]) begin
      step();
      chk_all("ar_run", ar_seq[i], 0, (ar_seq[i] == 3) ? 1 : 0, 1);
    end

    // enable gaps, one-shot 4
    load = 1'b1; load_val = 4'd4; mode = 1'b0; en = 1'b1;
    step();
    chk("gap_load.count", int'(count), 4);
    load = 1'b0;
    nborrow = 0;
    foreach (gap_seq[i]) begin
      en = (i % 2 == 0);
      step();
      chk("gap_run.count", int'(count), gap_seq[i]);
      nborrow += int'(borrow);
    end
    chk("gap_borrow_once", nborrow, 1);
    chk("gap_final_borrow", int'(borrow), 1);

    // auto-reload with reload value 1
    load = 1'b1; load_val = 4'd1; mode = 1'b1; en = 1'b1;
    step();
    chk_all("r1_load", 1, 0, 0, 1);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("r1_run", 1, 0, 1, 1);
    end

    // priority: load beats en, clr beats load, load 0 goes idle
    load = 1'b1; load_val = 4'd5; mode = 1'b0;
    step();
    load = 1'b0;
    step(); step(); step();
    chk("pri_pre.count", int'(count), 2);
    load = 1'b1; load_val = 4'd7;
    step();
    chk_all("pri_load_en", 7, 0, 0, 1);
    clr = 1'b1; load_val = 4'd9;
    step();
    chk_all("pri_clr_load", 0, 1, 0, 0);
    clr = 1'b0; load_val = 4'd0;
    step();
    chk_all("pri_load0", 0, 1, 0, 0);
    load = 1'b0;
    step();
    chk_all("pri_load0_hold", 0, 1, 0, 0);

    // clr drops a pending borrow; rst mid-count
    load = 1'b1; load_val = 4'd1; mode = 1'b1;
    step();
    load = 1'b0; clr = 1'b1;
    step();
    chk_all("clr_drop_borrow", 0, 1, 0, 0);
    clr = 1'b0;
    load = 1'b1; load_val = 4'd6; mode = 1'b0;
    step();
    load = 1'b0;
    step();
    chk("rst_mid_pre.count", int'(count), 5);
    rst = 1'b1;
    step();
    chk_all("rst_mid", 0, 1, 0, 0);
    rst = 1'b0;

    // full range auto-reload 15
    load = 1'b1; load_val = 4'd15; mode = 1'b1; en = 1'b1;
    step();
    chk_all("fr_load", 15, 0, 0, 1);
    load = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      step();
      cyc++;
      if (borrow) break;
    end
    chk("fr_borrow_cycles", cyc, 15);
    chk_all("fr_reload", 15, 0, 1, 1);
    step();
    chk_all("fr_after", 14, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
# sync_down_counter

Synchronous, loadable down-counter with one-shot and auto-reload modes. It is the counting-down counterpart of the team's ripple up-counter. Every bit is clocked by the single clock `clk`; there are no derived or rippled clocks. It serves as a programmable interval timer or event-count divider in the same designs. A registered `borrow` pulse allows cascading and interrupt generation.

## Interface

**Parameters**
- `WIDTH`, default 4: counter width in bits. Legal range is 2..32.

**Ports**
- `clk` (in, 1): clock. All state changes on its rising edge.
- `rst` (in, 1): synchronous, active-high reset.
- `clr` (in, 1): synchronous clear. Returns the block to IDLE.
- `load` (in, 1): load request. Captures `load_val` and `mode`.
- `load_val` (in, WIDTH): start/reload value.
- `mode` (in, 1): 0 = one-shot, 1 = auto-reload. Sampled only when `load`=1.
- `en` (in, 1): count enable. One decrement per cycle with `en`=1 while in RUN.
- `count` (out, WIDTH): current count, registered.
- `zero` (out, 1): registered; high exactly when `count`==0.
- `borrow` (out, 1): registered single-cycle pulse on terminal count.
- `busy` (out, 1): registered; high while in RUN.

## Operation

**Internal registers**
- `reload_reg` (WIDTH bits)
- `mode_reg` (1 bit)
- `state`, with values {IDLE, RUN}

**Priority per clock edge:** `rst` > `clr` > `load` > `en` > hold.

**`rst`**
- `count`=0, `reload_reg`=0, `mode_reg`=0.
- `state`=IDLE, `zero`=1, `borrow`=0, `busy`=0.

**`clr`**
- Same as reset, except `reload_reg` and `mode_reg` are retained.

**`load`** (allowed in any state)
- `count` ← `load_val`, `reload_reg` ← `load_val`, `mode_reg` ← `mode`, `borrow`=0.
- `state` ← RUN if `load_val`≠0, else IDLE.
- A load in the same cycle as `en` takes effect and suppresses the decrement.

**IDLE**
- `count` holds and `en` is ignored.
- Leave IDLE only via `load` with a nonzero value.

**RUN, `en`=1**
- If `count`>1: `count` ← `count`−1, `borrow`=0.
- If `count`==1 and `mode_reg`=0: `count` ← 0, `borrow`=1, `state` ← IDLE.
- If `count`==1 and `mode_reg`=1: `count` ← `reload_reg`, `borrow`=1, stay in RUN. The value 0 is never displayed in auto-reload.

**RUN, `en`=0**
- `count` holds, `borrow`=0.

**Outputs**
- `zero` and `busy` are updated in the same edge as `count`, so they are always consistent with it.
- `borrow` is never high for two consecutive cycles unless `reload_reg`==1 in auto-reload. In that case `borrow` is high on every enabled cycle and `count` stays at 1.

**Arithmetic**
- Unsigned, modulo 2^WIDTH.
- Underflow below 0 cannot occur, because RUN never decrements from 0.
- `load_val` = all-ones is legal. It gives a period of 2^WIDTH−1 enabled cycles.

## Timing

- All outputs are registered. A change on inputs at edge k is visible on outputs after edge k.
- The count sequence after loading N (N>0) with `en` held high:
  - one-shot: N, N−1, …, 1, 0, then holds at 0.
  - auto-reload: N, N−1, …, 1, N, …
- In one-shot mode, `borrow` is high during exactly the cycle in which `count` first shows 0. In auto-reload mode, it is high during the cycle in which `count` shows the reloaded N.
- The interval from load to first `borrow` is N enabled cycles.
- `busy` falls on the same edge that `borrow` rises in one-shot mode.
- Reset or `clr` asserted mid-count: outputs take reset values on the next edge. Any pending `borrow` is dropped.
- Reset and `load` asserted together: reset wins, and `load_val` is not captured.
- Gaps in `en` stretch the interval without changing the sequence.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `load`=1, `load_val`=9. Required: `count`=0, `zero`=1, `busy`=0, `borrow`=0.
- **One-shot:** `WIDTH`=4, load 5 with `mode`=0, `en`=1. Required:
  - `count` shows 5,4,3,2,1,0.
  - `borrow` is high only in the cycle `count`=0; `zero`=1 from that cycle.
  - `busy`=0 from that cycle.
  - `count` holds at 0 for 3 more `en` cycles.
- **Auto-reload:** load 3 with `mode`=1, `en`=1 for 9 cycles. Required:
  - `count` shows 3,2,1,3,2,1,3,2,1.
  - `borrow` is high exactly when `count` shows each reloaded 3.
  - `zero` never asserts.
- **Enable gaps and reload edge case:** load 4 and toggle `en` 1,0,1,0,… Required: `count` steps 4,3,3,2,2,1,1,0, with `borrow` high once. Then load 1 with `mode`=1 and `en`=1: `count` stays 1 and `borrow` is high every cycle.
- **Priority:**
  - Mid-run at `count`=2, assert `load`=7 together with `en` → `count`=7, no decrement.
  - Next cycle assert `clr` together with `load` → `count`=0, IDLE.
  - Load 0 → `busy`=0, `zero`=1.
- **Full range:** `WIDTH`=4, load 15 with `mode`=1. Required: the first `borrow` arrives 15 enabled cycles after load, and `count` returns to 15.
